// File: rtl/ovi_memop_bridge.sv
// Bridge between the scalar core issue stage and the OVI port of a vector unit:
// issue credit/outstanding tracking plus store (VPU->FIFO->core) and load (core->VPU) memop windows.
module ovi_memop_bridge #(
    parameter int DATA_W          = 512,
    parameter int BUF_DEPTH       = 32,
    parameter int ISSUE_CREDITS   = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SBID_W          = 5,
    parameter int VL_W            = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CORE_VALID,
    input  logic [31:0]       CORE_INSTR,
    input  logic [VL_W-1:0]   CORE_VL,
    input  logic [1:0]        CORE_SEW,
    output logic              CORE_HALT,
    output logic              CORE_DONE_VALID,
    output logic [63:0]       CORE_DONE_DATA,
    output logic              VPU_ISSUE_VALID,
    output logic [SBID_W-1:0] VPU_ISSUE_SBID,
    input  logic              VPU_ISSUE_CREDIT,
    input  logic              VPU_DONE_VALID,
    input  logic [63:0]       VPU_DONE_DATA,
    input  logic              VPU_SYNC_START,
    output logic              VPU_SYNC_END,
    output logic [SBID_W-1:0] VPU_MEMOP_SBID,
    input  logic              VPU_STORE_VALID,
    input  logic [DATA_W-1:0] VPU_STORE_DATA,
    output logic              VPU_STORE_CREDIT,
    output logic              VPU_LOAD_VALID,
    output logic [DATA_W-1:0] VPU_LOAD_DATA,
    output logic              ST_OUT_VALID,
    input  logic              ST_OUT_READY,
    output logic [DATA_W-1:0] ST_OUT_DATA,
    input  logic              LD_IN_VALID,
    output logic              LD_IN_READY,
    input  logic [DATA_W-1:0] LD_IN_DATA,
    output logic              ERR_OVF,
    output logic [1:0]        DBG_STATE
);

    localparam int CRED_W = $clog2(ISSUE_CREDITS + 1);
    localparam int OUTS_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PKT_W  = VL_W + 1;
    localparam int DSH    = $clog2(DATA_W);

    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_SEND = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic [OUTS_W-1:0]   outs_q, outs_d;
    logic [SBID_W-1:0]   sbid_q, sbid_d;
    logic [SBID_W-1:0]   memop_sbid_q, memop_sbid_d;
    logic                is_store_q, is_store_d;
    logic [PKT_W-1:0]    n_pkts_q, n_pkts_d;
    logic [PKT_W-1:0]    pkt_q, pkt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                load_valid_q, load_valid_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [DATA_W-1:0]   mem_q [BUF_DEPTH];

    logic [6:0]  opcode;
    logic        instr_load, instr_store, instr_mem;
    logic        fire;
    logic [63:0] vl_bits, pkts64;
    logic        window_end;
    logic        push_req, push, pop, full, ld_beat;
    logic        unused_bits;

    assign opcode      = CORE_INSTR[6:0];
    assign instr_load  = (opcode == OPC_LOAD);
    assign instr_store = (opcode == OPC_STORE);
    assign instr_mem   = instr_load | instr_store;

    // A memop only issues into an empty pipe so its window cannot interleave with arithmetic.
    assign fire = (state_q == S_IDLE) & CORE_VALID & (credits_q != '0)
                & (outs_q < OUTS_W'(MAX_OUTSTANDING)) & !(instr_mem & (outs_q != '0));

    assign vl_bits = 64'(CORE_VL) << (32'(CORE_SEW) + 32'd3);
    assign pkts64  = (vl_bits + 64'(DATA_W - 1)) >> DSH;

    assign window_end = ((state_q == S_RECV) | (state_q == S_SEND)) & (pkt_q == n_pkts_q);
    assign full       = (cnt_q == CNT_W'(BUF_DEPTH));
    assign push_req   = (state_q == S_RECV) & !window_end & VPU_STORE_VALID;
    assign push       = push_req & !full;
    assign pop        = (cnt_q != '0) & ST_OUT_READY;
    assign ld_beat    = (state_q == S_SEND) & !window_end & LD_IN_VALID;

    assign unused_bits = ^{CORE_INSTR[31:7], pkts64[63:PKT_W]};

    always_comb begin
        state_d      = state_q;
        credits_d    = credits_q;
        outs_d       = outs_q;
        sbid_d       = sbid_q;
        memop_sbid_d = memop_sbid_q;
        is_store_d   = is_store_q;
        n_pkts_d     = n_pkts_q;
        pkt_d        = pkt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        err_d        = err_q | (push_req & full);
        load_valid_d = ld_beat;
        load_data_d  = ld_beat ? LD_IN_DATA : load_data_q;

        // Returned credits beyond the reset allotment are dropped.
        if (fire && !VPU_ISSUE_CREDIT) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!fire && VPU_ISSUE_CREDIT && (credits_q < CRED_W'(ISSUE_CREDITS))) begin
            credits_d = credits_q + CRED_W'(1);
        end

        if (fire && !VPU_DONE_VALID) begin
            outs_d = outs_q + OUTS_W'(1);
        end else if (!fire && VPU_DONE_VALID && (outs_q != '0)) begin
            outs_d = outs_q - OUTS_W'(1);
        end

        if (fire) begin
            sbid_d = sbid_q + SBID_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (fire && instr_mem) begin
                    memop_sbid_d = sbid_q;
                    is_store_d   = instr_store;
                    n_pkts_d     = PKT_W'(pkts64);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (VPU_SYNC_START) begin
                    pkt_d   = '0;
                    state_d = is_store_q ? S_RECV : S_SEND;
                end else if (VPU_DONE_VALID) begin
                    state_d = S_IDLE;
                end
            end
            S_RECV, S_SEND: begin
                if (window_end) begin
                    state_d = S_WAIT;
                end else if (push_req || ld_beat) begin
                    pkt_d = pkt_q + PKT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            credits_q    <= CRED_W'(ISSUE_CREDITS);
            outs_q       <= '0;
            sbid_q       <= '0;
            memop_sbid_q <= '0;
            is_store_q   <= 1'b0;
            n_pkts_q     <= '0;
            pkt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            outs_q       <= outs_d;
            sbid_q       <= sbid_d;
            memop_sbid_q <= memop_sbid_d;
            is_store_q   <= is_store_d;
            n_pkts_q     <= n_pkts_d;
            pkt_q        <= pkt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
        end
    end

    // Storage array needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= VPU_STORE_DATA;
        end
    end

    assign CORE_HALT        = !fire | (state_q != S_IDLE);
    assign CORE_DONE_VALID  = VPU_DONE_VALID;
    assign CORE_DONE_DATA   = VPU_DONE_DATA;
    assign VPU_ISSUE_VALID  = fire;
    assign VPU_ISSUE_SBID   = sbid_q;
    assign VPU_SYNC_END     = window_end;
    assign VPU_MEMOP_SBID   = memop_sbid_q;
    assign VPU_STORE_CREDIT = pop;
    assign VPU_LOAD_VALID   = load_valid_q;
    assign VPU_LOAD_DATA    = load_data_q;
    assign ST_OUT_VALID     = (cnt_q != '0);
    assign ST_OUT_DATA      = mem_q[rd_ptr_q];
    assign LD_IN_READY      = (state_q == S_SEND) & !window_end;
    assign ERR_OVF          = err_q;
    assign DBG_STATE        = state_q;

endmodule
